// File: rtl/snake_pkg.sv
// Shared definitions for the snake game-step scheduler: state encoding,
// level width and default period constants.
package snake_pkg;

    localparam int unsigned LEVEL_W = 4;

    localparam int unsigned DEF_PERIOD_BASE    = 10_000_000;
    localparam int unsigned DEF_PERIOD_DEC     = 500_000;
    localparam int unsigned DEF_PERIOD_MIN     = 2_000_000;
    localparam int unsigned DEF_MAX_LEVEL      = 15;
    localparam int unsigned DEF_FOOD_PER_LEVEL = 4;
    localparam int unsigned DEF_HARD_LEVEL     = 4;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RUN      = 3'd1,
        S_WAIT_ACK = 3'd2,
        S_PAUSED   = 3'd3,
        S_OVER     = 3'd4
    } sched_state_t;

endpackage

// File: rtl/step_scheduler_if.sv
// Control/handshake bundle between the step scheduler and the snake datapath.
interface step_scheduler_if;
    import snake_pkg::*;

    logic               hard;
    logic               start;
    logic               pause;
    logic               food_eaten;
    logic               game_over;
    logic               step_ack;
    logic               step_req;
    logic [LEVEL_W-1:0] level;
    logic               running;
    logic               overrun;

    modport master (
        output hard, start, pause, food_eaten, game_over, step_ack,
        input  step_req, level, running, overrun
    );

    modport slave (
        input  hard, start, pause, food_eaten, game_over, step_ack,
        output step_req, level, running, overrun
    );

endinterface

// File: rtl/period_calc.sv
// Step period for a given speed level, clamped below at PERIOD_MIN without
// wrapping when the level reduction exceeds the base period.
module period_calc
    import snake_pkg::*;
#(
    parameter int unsigned PERIOD_BASE = DEF_PERIOD_BASE,
    parameter int unsigned PERIOD_DEC  = DEF_PERIOD_DEC,
    parameter int unsigned PERIOD_MIN  = DEF_PERIOD_MIN
) (
    input  logic [LEVEL_W-1:0] i_level,
    output logic [31:0]        o_period
);

    logic [31:0] w_dec;
    logic [31:0] w_diff;

    always_comb begin
        w_dec  = 32'(i_level) * PERIOD_DEC;
        w_diff = PERIOD_BASE - w_dec;
        if (w_dec >= PERIOD_BASE) begin
            o_period = PERIOD_MIN;
        end else if (w_diff < PERIOD_MIN) begin
            o_period = PERIOD_MIN;
        end else begin
            o_period = w_diff;
        end
    end

endmodule

// File: rtl/step_scheduler.sv
// Game-step tick source: one step request per programmable period, handshaked
// with the datapath, with level progression, pause and game-over handling.
//
//   state    | meaning
//   ---------+------------------------------------------------------
//   IDLE     | after reset, waiting for start
//   RUN      | counting towards the next step
//   WAIT_ACK | step requested, counting on, waiting for step_ack
//   PAUSED   | counter frozen until the next pause pulse
//   OVER     | collision seen, level/overrun held for display
module step_scheduler
    import snake_pkg::*;
#(
    parameter int unsigned PERIOD_BASE    = DEF_PERIOD_BASE,
    parameter int unsigned PERIOD_DEC     = DEF_PERIOD_DEC,
    parameter int unsigned PERIOD_MIN     = DEF_PERIOD_MIN,
    parameter int unsigned MAX_LEVEL      = DEF_MAX_LEVEL,
    parameter int unsigned FOOD_PER_LEVEL = DEF_FOOD_PER_LEVEL,
    parameter int unsigned HARD_LEVEL     = DEF_HARD_LEVEL
) (
    input  logic             clk,
    input  logic             rst_n,
    step_scheduler_if.slave  bus
);

    localparam int unsigned FOOD_W = (FOOD_PER_LEVEL > 1) ? $clog2(FOOD_PER_LEVEL) : 1;
    localparam logic [FOOD_W-1:0]  FOOD_LAST = FOOD_W'(FOOD_PER_LEVEL - 1);
    localparam logic [LEVEL_W-1:0] LVL_MAX   = LEVEL_W'(MAX_LEVEL);
    localparam logic [LEVEL_W-1:0] LVL_HARD  = LEVEL_W'(HARD_LEVEL);

    sched_state_t       r_state, w_state_nxt;
    logic [31:0]        r_cnt, r_period_q, w_period;
    logic [LEVEL_W-1:0] r_level, w_start_level, w_calc_level;
    logic [FOOD_W-1:0]  r_food_cnt;
    logic               r_step_req, r_running, r_overrun, r_pause_pend;
    logic               w_active, w_start_acc, w_over_acc, w_counting, w_term;
    logic               w_food_inc, w_level_up;

    assign w_active      = (r_state == S_RUN) || (r_state == S_WAIT_ACK) || (r_state == S_PAUSED);
    assign w_start_acc   = ((r_state == S_IDLE) || (r_state == S_OVER)) && bus.start;
    assign w_over_acc    = w_active && bus.game_over;
    assign w_counting    = !w_over_acc &&
                           (((r_state == S_RUN) && !bus.pause) || (r_state == S_WAIT_ACK));
    assign w_term        = (r_cnt == r_period_q - 32'd1);
    assign w_food_inc    = w_active && bus.food_eaten && !bus.game_over;
    assign w_level_up    = w_food_inc && (r_food_cnt == FOOD_LAST);
    assign w_start_level = bus.hard ? LVL_HARD : '0;
    // Non-start reloads use the current level, so a same-cycle level-up waits a period
    assign w_calc_level  = w_start_acc ? w_start_level : r_level;

    period_calc #(
        .PERIOD_BASE (PERIOD_BASE),
        .PERIOD_DEC  (PERIOD_DEC),
        .PERIOD_MIN  (PERIOD_MIN)
    ) u_period_calc (
        .i_level  (w_calc_level),
        .o_period (w_period)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_OVER: begin
                if (bus.start) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (bus.game_over)  w_state_nxt = S_OVER;
                else if (bus.pause) w_state_nxt = S_PAUSED;
                else if (w_term)    w_state_nxt = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (bus.game_over)     w_state_nxt = S_OVER;
                else if (bus.step_ack) w_state_nxt = r_pause_pend ? S_PAUSED : S_RUN;
            end
            S_PAUSED: begin
                if (bus.game_over)  w_state_nxt = S_OVER;
                else if (bus.pause) w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_period_q   <= '0;
            r_level      <= '0;
            r_food_cnt   <= '0;
            r_step_req   <= 1'b0;
            r_running    <= 1'b0;
            r_overrun    <= 1'b0;
            r_pause_pend <= 1'b0;
        end else begin
            // Request is the registered image of WAIT_ACK, dropped at once on game over
            r_step_req <= (r_state == S_WAIT_ACK) && !w_over_acc;
            r_running  <= (w_state_nxt == S_RUN) || (w_state_nxt == S_WAIT_ACK);
            if (w_start_acc) begin
                r_cnt        <= '0;
                r_food_cnt   <= '0;
                r_overrun    <= 1'b0;
                r_pause_pend <= 1'b0;
                r_level      <= w_start_level;
                r_period_q   <= w_period;
            end else begin
                if (w_counting) begin
                    if (w_term) begin
                        r_cnt      <= '0;
                        r_period_q <= w_period;
                        if ((r_state == S_WAIT_ACK) && !bus.step_ack) r_overrun <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                if (w_food_inc) begin
                    if (w_level_up) begin
                        r_food_cnt <= '0;
                        if (r_level < LVL_MAX) r_level <= r_level + LEVEL_W'(1);
                    end else begin
                        r_food_cnt <= r_food_cnt + FOOD_W'(1);
                    end
                end
                if (w_over_acc) begin
                    r_pause_pend <= 1'b0;
                end else if (r_state == S_WAIT_ACK) begin
                    if (bus.step_ack)   r_pause_pend <= 1'b0;
                    else if (bus.pause) r_pause_pend <= 1'b1;
                end
            end
        end
    end

    assign bus.step_req = r_step_req;
    assign bus.level    = r_level;
    assign bus.running  = r_running;
    assign bus.overrun  = r_overrun;

endmodule

// File: tb/tb_step_scheduler.sv
// Bench for step_scheduler with small periods; outputs are compared every cycle
// against a rule-level game model, plus directed timing/boundary checks.
module tb_step_scheduler;
    import snake_pkg::*;

    localparam int PB  = 20;
    localparam int PD  = 4;
    localparam int PM  = 8;
    localparam int FPL = 2;
    localparam int HL  = 2;
    localparam int ML  = 15;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_WAIT  = 2;
    localparam int M_PAUSE = 3;
    localparam int M_OVER  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    step_scheduler_if bus();

    step_scheduler #(
        .PERIOD_BASE    (PB),
        .PERIOD_DEC     (PD),
        .PERIOD_MIN     (PM),
        .MAX_LEVEL      (ML),
        .FOOD_PER_LEVEL (FPL),
        .HARD_LEVEL     (HL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    int m_mode, m_cnt, m_period, m_level, m_food;
    bit m_req, m_run, m_ovr, m_pend;

    function automatic int period_of(int l);
        int p;
        p = PB - l * PD;
        return (p < PM) ? PM : p;
    endfunction

    function automatic logic [6:0] exp_vec();
        return {m_req, m_run, m_ovr, 4'(m_level)};
    endfunction

    function automatic logic [6:0] act_vec();
        return {bus.step_req, bus.running, bus.overrun, bus.level};
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_cnt = 0; m_period = 0; m_level = 0; m_food = 0;
        m_req = 0; m_run = 0; m_ovr = 0; m_pend = 0;
    endtask

    task automatic model_step();
        int pm;
        bit act, go, term, cnt_on;
        int old_per;
        pm      = m_mode;
        act     = (pm == M_RUN) || (pm == M_WAIT) || (pm == M_PAUSE);
        go      = act && bus.game_over;
        term    = ((pm == M_RUN) || (pm == M_WAIT)) && (m_cnt == m_period - 1);
        old_per = period_of(m_level);
        cnt_on  = 0;
        m_req   = (pm == M_WAIT) && !go;
        if (!act) begin
            if (bus.start) begin
                m_mode = M_RUN; m_cnt = 0; m_food = 0; m_ovr = 0; m_pend = 0;
                m_level  = bus.hard ? HL : 0;
                m_period = period_of(m_level);
            end
        end else begin
            if (bus.food_eaten && !go) begin
                m_food++;
                if (m_food == FPL) begin
                    m_food = 0;
                    if (m_level < ML) m_level++;
                end
            end
            if (go) begin
                m_mode = M_OVER;
                m_pend = 0;
            end else begin
                case (pm)
                    M_RUN: begin
                        if (bus.pause) m_mode = M_PAUSE;
                        else begin
                            cnt_on = 1;
                            if (term) m_mode = M_WAIT;
                        end
                    end
                    M_WAIT: begin
                        cnt_on = 1;
                        if (bus.step_ack) begin
                            m_mode = m_pend ? M_PAUSE : M_RUN;
                            m_pend = 0;
                        end else if (bus.pause) m_pend = 1;
                    end
                    M_PAUSE: if (bus.pause) m_mode = M_RUN;
                    default: ;
                endcase
                if (cnt_on) begin
                    if (term) begin
                        m_cnt    = 0;
                        m_period = old_per;
                        if (pm == M_WAIT && !bus.step_ack) m_ovr = 1;
                    end else m_cnt++;
                end
            end
        end
        m_run = (m_mode == M_RUN) || (m_mode == M_WAIT);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        bus.start = 0; bus.pause = 0; bus.food_eaten = 0;
    endtask

    task automatic start_game(bit h);
        bus.hard = h; bus.start = 1;
        cyc();
    endtask

    task automatic test_reset();
        #1 rst_n = 0;
        model_reset();
        #10;
        total++;
        if (act_vec() !== 7'd0) begin bad++; $display("FAIL reset_state got=%b exp=%b", act_vec(), 7'd0); end
        @(negedge clk) rst_n = 1;
        cyc();
        total++;
        if (act_vec() !== exp_vec()) begin bad++; $display("FAIL reset_idle got=%b exp=%b", act_vec(), exp_vec()); end
    endtask

    task automatic test_first_step();
        int first = -1, second = -1;
        logic prev = 0;
        start_game(0);
        for (int i = 1; i <= 60; i++) begin
            cyc();
            total++;
            if (act_vec() !== exp_vec()) begin bad++; $display("FAIL first_step_cyc%0d got=%b exp=%b", i, act_vec(), exp_vec()); end
            if (bus.step_req && !prev) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
            prev = bus.step_req;
            bus.step_ack = bus.step_req;
        end
        bus.step_ack = 0;
        total++;
        if (first !== 21) begin bad++; $display("FAIL first_req_edge got=%0d exp=21", first); end
        total++;
        if (second - first !== 20) begin bad++; $display("FAIL req_spacing got=%0d exp=20", second - first); end
    endtask

    task automatic test_food_levels();
        int last = -1, spacing = -1;
        logic prev = 0;
        bus.food_eaten = 1; cyc(); cyc();
        bus.food_eaten = 1; cyc(); cyc();
        total++;
        if (bus.level !== 4'd1) begin bad++; $display("FAIL level_after_2_food got=%0d exp=1", bus.level); end
        for (int i = 0; i < 180; i++) begin
            if (i < 70) bus.food_eaten = (i % 2 == 0) || ($urandom_range(0, 3) == 0);
            cyc();
            total++;
            if (act_vec() !== exp_vec()) begin bad++; $display("FAIL food_cyc%0d got=%b exp=%b", i, act_vec(), exp_vec()); end
            if (bus.step_req && !prev && i >= 100) begin
                if (last >= 0) spacing = i - last;
                last = i;
            end
            prev = bus.step_req;
            bus.step_ack = bus.step_req;
        end
        bus.step_ack = 0;
        total++;
        if (bus.level !== 4'd15) begin bad++; $display("FAIL level_saturate got=%0d exp=15", bus.level); end
        total++;
        if (spacing !== 8) begin bad++; $display("FAIL clamped_period got=%0d exp=8", spacing); end
    endtask

    task automatic test_hard();
        int first = -1;
        bus.game_over = 1; cyc(); bus.game_over = 0;
        total++;
        if (act_vec() !== exp_vec()) begin bad++; $display("FAIL over_hold got=%b exp=%b", act_vec(), exp_vec()); end
        start_game(1);
        total++;
        if (bus.level !== 4'd2) begin bad++; $display("FAIL hard_level got=%0d exp=2", bus.level); end
        for (int i = 1; i <= 40 && first < 0; i++) begin
            cyc();
            total++;
            if (act_vec() !== exp_vec()) begin bad++; $display("FAIL hard_cyc%0d got=%b exp=%b", i, act_vec(), exp_vec()); end
            if (bus.step_req) first = i;
        end
        total++;
        if (first !== 13) begin bad++; $display("FAIL hard_first_req got=%0d exp=13", first); end
    endtask

    task automatic test_overrun();
        int dropped = 0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            total++;
            if (act_vec() !== exp_vec()) begin bad++; $display("FAIL overrun_cyc%0d got=%b exp=%b", i, act_vec(), exp_vec()); end
            if (!bus.step_req) dropped++;
        end
        total++;
        if (dropped !== 0) begin bad++; $display("FAIL req_held got=%0d exp=0", dropped); end
        total++;
        if (bus.overrun !== 1'b1) begin bad++; $display("FAIL overrun_set got=%b exp=1", bus.overrun); end
        bus.step_ack = 1; cyc(); bus.step_ack = 0; cyc();
        total++;
        if ({bus.step_req, bus.overrun} !== 2'b01) begin bad++; $display("FAIL ack_clears_req got=%b exp=01", {bus.step_req, bus.overrun}); end
    endtask

    task automatic test_pause();
        int rise = -1;
        bus.game_over = 1; cyc(); bus.game_over = 0;
        start_game(0);
        for (int i = 0; i < 5; i++) cyc();
        bus.pause = 1; cyc();
        for (int i = 0; i < 100; i++) begin
            cyc();
            total++;
            if (act_vec() !== exp_vec()) begin bad++; $display("FAIL paused_cyc%0d got=%b exp=%b", i, act_vec(), exp_vec()); end
        end
        total++;
        if (bus.running !== 1'b0) begin bad++; $display("FAIL paused_running got=%b exp=0", bus.running); end
        bus.pause = 1; cyc();
        for (int i = 1; i <= 40 && rise < 0; i++) begin
            cyc();
            total++;
            if (act_vec() !== exp_vec()) begin bad++; $display("FAIL resume_cyc%0d got=%b exp=%b", i, act_vec(), exp_vec()); end
            if (bus.step_req) rise = i;
        end
        total++;
        if (rise !== 16) begin bad++; $display("FAIL resume_req_edge got=%0d exp=16", rise); end
        bus.pause = 1; cyc();
        bus.step_ack = 1; cyc(); bus.step_ack = 0; cyc();
        total++;
        if ({bus.step_req, bus.running} !== 2'b00 || act_vec() !== exp_vec()) begin
            bad++; $display("FAIL pend_pause got=%b exp=%b", act_vec(), exp_vec());
        end
        bus.pause = 1; cyc();
    endtask

    task automatic test_game_over();
        int guard = 0;
        while (!bus.step_req && guard < 60) begin cyc(); guard++; end
        total++;
        if (!bus.step_req) begin bad++; $display("FAIL wait_req_timeout got=0 exp=1"); end
        for (int i = 0; i < 25; i++) cyc();
        bus.game_over = 1; cyc(); bus.game_over = 0;
        total++;
        if ({bus.step_req, bus.running, bus.overrun} !== 3'b001 || act_vec() !== exp_vec()) begin
            bad++; $display("FAIL game_over got=%b exp=%b", act_vec(), exp_vec());
        end
        start_game(0);
        total++;
        if ({bus.overrun, bus.running, bus.level} !== 6'b010000) begin
            bad++; $display("FAIL restart got=%b exp=010000", {bus.overrun, bus.running, bus.level});
        end
    endtask

    task automatic test_random();
        int ack_wait = -1;
        for (int i = 0; i < 800; i++) begin
            bus.food_eaten = ($urandom_range(0, 5) == 0);
            bus.pause      = ($urandom_range(0, 39) == 0);
            bus.game_over  = ($urandom_range(0, 149) == 0);
            bus.start      = ($urandom_range(0, 19) == 0);
            bus.hard       = $urandom_range(0, 1);
            cyc();
            bus.game_over = 0;
            total++;
            if (act_vec() !== exp_vec()) begin bad++; $display("FAIL random_cyc%0d got=%b exp=%b", i, act_vec(), exp_vec()); end
            if (bus.step_req && ack_wait < 0) ack_wait = $urandom_range(0, 25);
            bus.step_ack = 0;
            if (ack_wait == 0) begin bus.step_ack = 1; ack_wait = -1; end
            else if (ack_wait > 0) ack_wait--;
        end
        bus.step_ack = 0;
    endtask

    task automatic test_reset_mid();
        bus.game_over = 1; cyc(); bus.game_over = 0;
        start_game(1);
        for (int i = 0; i < 20; i++) cyc();
        rst_n = 0;
        #1;
        total++;
        if (act_vec() !== 7'd0) begin bad++; $display("FAIL reset_mid got=%b exp=%b", act_vec(), 7'd0); end
        model_reset();
        @(negedge clk) rst_n = 1;
        cyc();
        total++;
        if (act_vec() !== exp_vec()) begin bad++; $display("FAIL after_reset got=%b exp=%b", act_vec(), exp_vec()); end
    endtask

    initial begin
        bus.hard = 0; bus.start = 0; bus.pause = 0; bus.food_eaten = 0;
        bus.game_over = 0; bus.step_ack = 0;
        model_reset();
        test_reset();
        test_first_step();
        test_food_levels();
        test_hard();
        test_overrun();
        test_pause();
        test_game_over();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/step_scheduler.md
# step_scheduler

Game-step scheduler for the snake datapath. It replaces the free-running fixed-ratio slow-clock divider with a controlled tick source. It generates one game-step request per programmable period, derived from `clk` with no derived clocks. It handshakes each step with the snake datapath, raises the speed level as food is eaten, and handles start, pause and game-over sequencing.

## Interface
Parameters:
- `PERIOD_BASE`, 10_000_000: step period in `clk` cycles at level 0.
- `PERIOD_DEC`, 500_000: period reduction per level.
- `PERIOD_MIN`, 2_000_000: lower clamp on the period.
- `MAX_LEVEL`, 15: level saturation value. Must fit in 4 bits.
- `FOOD_PER_LEVEL`, 4: food events per level increment. Must be ≥1.
- `HARD_LEVEL`, 4: starting level when `hard`=1.

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `hard`, in, 1: difficulty select. Sampled only on an accepted `start`.
- `start`, in, 1: one-cycle pulse that begins a game.
- `pause`, in, 1: one-cycle pulse that toggles pause.
- `food_eaten`, in, 1: one-cycle pulse from the datapath.
- `game_over`, in, 1: level signal from the datapath (collision).
- `step_req`, out, 1: request to the datapath to advance one step.
- `step_ack`, in, 1: datapath has completed the step.
- `level`, out, 4: current speed level.
- `running`, out, 1: high in RUN and WAIT_ACK.
- `overrun`, out, 1: sticky flag, set when a step was missed.

## Operation
- States:
  - IDLE: reset state.
  - RUN
  - WAIT_ACK
  - PAUSED
  - OVER
- Reset values: state=IDLE, cnt=0, level=0, food_cnt=0, `step_req`=0, `running`=0, `overrun`=0.
- `period` = max(PERIOD_BASE − level·PERIOD_DEC, PERIOD_MIN).
  - Computed in 32-bit unsigned arithmetic.
  - If level·PERIOD_DEC ≥ PERIOD_BASE, the result is PERIOD_MIN, with no wrap.
  - `period_q` is latched at start and at every counter wrap, so a level change takes effect from the next period.
- IDLE or OVER + `start` → RUN. On entry: cnt=0, food_cnt=0, `overrun`=0, level = `hard` ? HARD_LEVEL : 0, `period_q` loaded. `start` is ignored in every other state.
- cnt advances every cycle in RUN and WAIT_ACK. When cnt == `period_q`−1 (terminal):
  - cnt goes to 0.
  - In RUN: go to WAIT_ACK and set `step_req`=1.
  - In WAIT_ACK: set `overrun`=1. `step_req` stays high and no second request is queued.
- WAIT_ACK + `step_ack` → RUN, and `step_req`=0 on the next edge. `step_ack` outside WAIT_ACK is ignored.
- `pause` pulse:
  - RUN → PAUSED. cnt is frozen.
  - PAUSED → RUN. Counting resumes from the frozen cnt.
  - In WAIT_ACK the pulse is latched into `pause_pend` and applied on ack: go to PAUSED instead of RUN.
- `food_eaten` in RUN, WAIT_ACK or PAUSED increments food_cnt. At FOOD_PER_LEVEL−1, food_cnt wraps to 0 and level increments, saturating at MAX_LEVEL. The pulse is ignored in IDLE and OVER.
- `game_over`=1 in RUN, WAIT_ACK or PAUSED → OVER.
  - `step_req`=0 and `pause_pend`=0.
  - level and `overrun` hold their values for display.
- Priority on the same cycle: `game_over` > `step_ack` > `pause` > terminal count. A food-driven level increment and a terminal wrap on the same cycle latch the old level's period.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- `start` accepted at edge 0 → cnt=0 at edge 1 → terminal at edge P → `step_req` high after edge P+1. Each later request follows P cycles after the previous terminal.
- Ack seen at edge k → `step_req` low after edge k+1. The same-cycle ack/`step_req` overlap is one cycle.
- `rst_n` asserted mid-operation clears all state immediately, asynchronously, including a pending `step_req`.

## Structure
- Shared package `snake_pkg`:
  - state enum `sched_state_t`.
  - default period constants.
  - `LEVEL_W`=4.
- Sub-module `period_calc`: level in, clamped 32-bit period out. It is combinational, and a register for it is optional.
- The FSM, counter, food counter and `overrun` stay in the top level.

## Test plan
Test parameters: PERIOD_BASE=20, PERIOD_DEC=4, PERIOD_MIN=8, FOOD_PER_LEVEL=2, HARD_LEVEL=2, MAX_LEVEL=15.
- Start with `hard`=0 and immediate ack → first `step_req` after edge 21, then every 20 cycles; `level`=0, `running`=1.
- 2 `food_eaten` pulses → `level`=1 and the period after the next wrap is 16. 8 more pulses → level 5, period clamped to 8. Continued pulses → level saturates at 15.
- Start with `hard`=1 → `level`=2, period 12.
- Hold `step_ack` low for 30 cycles → `step_req` stays continuously high as a single request, `overrun`=1. Ack → `step_req` low, `overrun` stays 1 until the next start.
- `pause` at cnt=5, wait 100 cycles, `pause` again → next `step_req` arrives 15 counting cycles later. `pause` during WAIT_ACK, then ack → state PAUSED.
- `game_over` during WAIT_ACK → `step_req`=0 and `running`=0 the next cycle; `start` → new game with `overrun`=0. `rst_n` low mid-RUN → all outputs 0 immediately.
